// File: rtl/sap1_mar.sv
// SAP-1 Memory Address Register.
// Drives the 4-bit address into the 16x8 program/data memory.
// RUN:   address is loaded from the W bus when Lm (load_n) is low.
// PROG:  address is taken from the front-panel switches on entry and
//        advanced one location per step press.
// SWEEP: address advances automatically, once every SWEEP_DIV clocks,
//        so the memory contents can be reviewed on the display.
// The mode switches, step button and address switches are asynchronous
// and are synchronized here. load_n and bus_in are already in this domain.

module sap1_mar #(
  parameter int ADDR_W      = 4,
  parameter int BUS_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SWEEP_DIV   = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [BUS_W-1:0]  bus_in,
  input  logic              load_n,
  input  logic              prog_mode,
  input  logic              sweep_en,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              step,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        mode
);

  // Divider needs at least one bit, even when SWEEP_DIV = 1.
  localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);

  // Encoding doubles as the mode output: 00 RUN, 01 PROG, 10 SWEEP.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_PROG  = 2'b01,
    ST_SWEEP = 2'b10
  } state_e;

  // Synchronizer chains: bit/entry 0 is the first stage, the top one is the synced value.
  logic [SYNC_STAGES-1:0] prog_sync_r;
  logic [SYNC_STAGES-1:0] sweep_sync_r;
  logic [SYNC_STAGES-1:0] step_sync_r;
  logic [ADDR_W-1:0]      sw_addr_sync_r [SYNC_STAGES];

  logic              prog_synced_s;
  logic              sweep_synced_s;
  logic              step_synced_s;
  logic [ADDR_W-1:0] sw_addr_synced_s;

  logic              step_prev_r;
  logic              step_pulse_s;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  div_nxt_s;

  // Upper bus bits carry data, not address; they are deliberately dropped.
  logic unused_bus_s;
  assign unused_bus_s = ^bus_in[BUS_W-1:ADDR_W];

  // Shift every asynchronous input through its synchronizer chain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prog_sync_r  <= {SYNC_STAGES{1'b0}};
      sweep_sync_r <= {SYNC_STAGES{1'b0}};
      step_sync_r  <= {SYNC_STAGES{1'b0}};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_addr_sync_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      prog_sync_r  <= {prog_sync_r[SYNC_STAGES-2:0], prog_mode};
      sweep_sync_r <= {sweep_sync_r[SYNC_STAGES-2:0], sweep_en};
      step_sync_r  <= {step_sync_r[SYNC_STAGES-2:0], step};
      sw_addr_sync_r[0] <= sw_addr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_addr_sync_r[i] <= sw_addr_sync_r[i-1];
      end
    end
  end

  assign prog_synced_s    = prog_sync_r[SYNC_STAGES-1];
  assign sweep_synced_s   = sweep_sync_r[SYNC_STAGES-1];
  assign step_synced_s    = step_sync_r[SYNC_STAGES-1];
  assign sw_addr_synced_s = sw_addr_sync_r[SYNC_STAGES-1];

  // Remember the previous synced step level for rising-edge detection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_prev_r <= 1'b0;
    end else begin
      step_prev_r <= step_synced_s;
    end
  end

  // One pulse per press, however long the button is held.
  assign step_pulse_s = step_synced_s & ~step_prev_r;

  // Target mode is a pure function of the synced switches.
  always_comb begin
    state_nxt_s = ST_RUN;
    if (!prog_synced_s) begin
      state_nxt_s = ST_RUN;
    end else if (sweep_synced_s) begin
      state_nxt_s = ST_SWEEP;
    end else begin
      state_nxt_s = ST_PROG;
    end
  end

  // Next address and divider. A mode change takes priority over any step,
  // load or sweep tick in the same cycle.
  always_comb begin
    addr_nxt_s = addr_r;
    div_nxt_s  = {DIV_W{1'b0}};
    if (state_nxt_s != state_r) begin
      div_nxt_s = {DIV_W{1'b0}};
      if (state_nxt_s == ST_PROG) begin
        addr_nxt_s = sw_addr_synced_s;
      end else begin
        addr_nxt_s = addr_r;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          div_nxt_s = {DIV_W{1'b0}};
          if (!load_n) begin
            addr_nxt_s = bus_in[ADDR_W-1:0];
          end else begin
            addr_nxt_s = addr_r;
          end
        end
        ST_PROG: begin
          div_nxt_s = {DIV_W{1'b0}};
          if (step_pulse_s) begin
            addr_nxt_s = addr_r + ADDR_W'(1);
          end else begin
            addr_nxt_s = addr_r;
          end
        end
        ST_SWEEP: begin
          if (div_r == DIV_LAST) begin
            div_nxt_s  = {DIV_W{1'b0}};
            addr_nxt_s = addr_r + ADDR_W'(1);
          end else begin
            div_nxt_s  = div_r + DIV_W'(1);
            addr_nxt_s = addr_r;
          end
        end
        default: begin
          div_nxt_s  = {DIV_W{1'b0}};
          addr_nxt_s = addr_r;
        end
      endcase
    end
  end

  // Mode, address and divider registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= ST_RUN;
      addr_r  <= {ADDR_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      div_r   <= div_nxt_s;
    end
  end

  assign address = addr_r;
  assign mode    = state_r;

endmodule

// File: tb/tb_sap1_mar.sv
// Self-checking bench for sap1_mar: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model that treats the
// synchronizers as a fixed input delay.

module tb_sap1_mar;

  localparam int ADDR_W = 4;
  localparam int BUS_W  = 8;
  localparam int S      = 2;
  localparam int DIV    = 4;

  logic              clk = 1'b0;
  logic              clr_n;
  logic [BUS_W-1:0]  bus_in;
  logic              load_n;
  logic              prog_mode;
  logic              sweep_en;
  logic [ADDR_W-1:0] sw_addr;
  logic              step;
  logic [ADDR_W-1:0] address;
  logic [1:0]        mode;

  int n_checks = 0;
  int n_errors = 0;

  // Model: input history (index 0 = values present before the current edge).
  int h_prog  [S+2];
  int h_sweep [S+2];
  int h_step  [S+2];
  int h_sw    [S+2];
  int m_mode;   // 0 RUN, 1 PROG, 2 SWEEP
  int m_addr;
  int m_cnt;    // clocks spent in SWEEP since entry

  sap1_mar #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .SYNC_STAGES(S), .SWEEP_DIV(DIV)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus_in    (bus_in),
    .load_n    (load_n),
    .prog_mode (prog_mode),
    .sweep_en  (sweep_en),
    .sw_addr   (sw_addr),
    .step      (step),
    .address   (address),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S+2; i++) begin
      h_prog[i] = 0; h_sweep[i] = 0; h_step[i] = 0; h_sw[i] = 0;
    end
    m_mode = 0; m_addr = 0; m_cnt = 0;
  endtask

  // Apply the mode/address rules for one clock edge.
  task automatic model_edge();
    int nm;
    int pulse;
    pulse = (h_step[S] == 1 && h_step[S+1] == 0) ? 1 : 0;
    if (h_prog[S] == 0)       nm = 0;
    else if (h_sweep[S] == 1) nm = 2;
    else                      nm = 1;
    if (nm != m_mode) begin
      if (nm == 1) m_addr = h_sw[S];
      m_cnt  = 0;
      m_mode = nm;
    end else if (m_mode == 0) begin
      if (load_n == 1'b0) m_addr = int'(bus_in) % (1 << ADDR_W);
    end else if (m_mode == 1) begin
      if (pulse == 1) m_addr = (m_addr + 1) % (1 << ADDR_W);
    end else begin
      m_cnt++;
      if (m_cnt % DIV == 0) m_addr = (m_addr + 1) % (1 << ADDR_W);
    end
  endtask

  // Advance n clocks, updating the model and comparing after every edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      if (clr_n) begin
        for (int i = S+1; i > 0; i--) begin
          h_prog[i] = h_prog[i-1]; h_sweep[i] = h_sweep[i-1];
          h_step[i] = h_step[i-1]; h_sw[i] = h_sw[i-1];
        end
        h_prog[0] = int'(prog_mode); h_sweep[0] = int'(sweep_en);
        h_step[0] = int'(step);      h_sw[0] = int'(sw_addr);
      end
      @(posedge clk);
      if (clr_n) model_edge();
      else       model_reset();
      #1;
      check("addr", 32'(address), 32'(m_addr));
      check("mode", 32'(mode), 32'(m_mode));
    end
  endtask

  task automatic assert_reset();
    clr_n = 1'b0;
    #1;
    model_reset();
    check("rst_addr_now", 32'(address), 32'd0);
    check("rst_mode_now", 32'(mode), 32'd0);
  endtask

  initial begin
    clr_n = 1'b0; bus_in = 8'h00; load_n = 1'b1; prog_mode = 1'b0;
    sweep_en = 1'b0; sw_addr = 4'h0; step = 1'b0;
    model_reset();
    #2;
    check("rst_addr", 32'(address), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    tick(3);

    // RUN load, then hold with load_n high
    bus_in = 8'hA9; load_n = 1'b0; tick(1);
    check("run_load", 32'(address), 32'd9);
    bus_in = 8'h05; load_n = 1'b1; tick(3);
    check("run_hold", 32'(address), 32'd9);

    // PROG entry on the third edge
    sw_addr = 4'd14; prog_mode = 1'b1; tick(2);
    check("prog_not_yet", 32'(mode), 32'd0);
    tick(1);
    check("prog_mode", 32'(mode), 32'd1);
    check("prog_entry", 32'(address), 32'd14);
    sw_addr = 4'd3; load_n = 1'b0; bus_in = 8'h07;   // both ignored in PROG
    step = 1'b1; tick(4); step = 1'b0; tick(4);
    check("step_15", 32'(address), 32'd15);
    load_n = 1'b1;
    step = 1'b1; tick(4); step = 1'b0; tick(4);
    check("step_wrap", 32'(address), 32'd0);
    step = 1'b1; tick(20); step = 1'b0; tick(4);
    check("long_hold", 32'(address), 32'd1);
    for (int p = 0; p < 2; p++) begin
      step = 1'b1; tick(4); step = 1'b0; tick(4);
    end
    check("at_3", 32'(address), 32'd3);

    // SWEEP from address 3; step and load_n ignored
    sweep_en = 1'b1; tick(3);
    check("sweep_mode", 32'(mode), 32'd2);
    check("sweep_hold", 32'(address), 32'd3);
    tick(4);
    check("sweep_4", 32'(address), 32'd4);
    step = 1'b1; load_n = 1'b0; bus_in = 8'h0F; tick(4);
    check("sweep_5", 32'(address), 32'd5);
    step = 1'b0; load_n = 1'b1; tick(4);
    check("sweep_6", 32'(address), 32'd6);

    // Back to PROG, then step edge coincides with PROG->RUN
    sw_addr = 4'd11; sweep_en = 1'b0; tick(3);
    check("resweep_prog", 32'(address), 32'd11);
    step = 1'b1; prog_mode = 1'b0; tick(3);
    check("simul_mode", 32'(mode), 32'd0);
    check("simul_addr", 32'(address), 32'd11);
    step = 1'b0; tick(4);
    check("run_keeps", 32'(address), 32'd11);

    // Re-entry into PROG reloads the switches
    sw_addr = 4'd2; prog_mode = 1'b1; tick(3);
    check("reentry", 32'(address), 32'd2);

    // Reset mid-SWEEP at address 7
    sw_addr = 4'd7; prog_mode = 1'b0; tick(3);
    prog_mode = 1'b1; tick(3);
    sweep_en = 1'b1; tick(3); tick(2);
    check("pre_rst_addr", 32'(address), 32'd7);
    check("pre_rst_mode", 32'(mode), 32'd2);
    assert_reset();
    tick(2);
    prog_mode = 1'b0; sweep_en = 1'b0;
    clr_n = 1'b1; tick(5);
    check("post_rst_addr", 32'(address), 32'd0);

    // Reset release with prog_mode still high re-enters PROG
    sw_addr = 4'd13; prog_mode = 1'b1; tick(4);
    assert_reset();
    tick(1);
    clr_n = 1'b1; tick(3);
    check("rst_reprog", 32'(address), 32'd13);

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) prog_mode = ~prog_mode;
      if ($urandom_range(0, 29) == 0) sweep_en = ~sweep_en;
      if ($urandom_range(0, 5) == 0)  step = ~step;
      if ($urandom_range(0, 9) == 0)  sw_addr = 4'($urandom);
      bus_in = 8'($urandom);
      load_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        tick(2);
        clr_n = 1'b1;
      end
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
